// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/size encodings and the address-phase bundle.
package ahb_pkg;

  localparam int AHB_ADDR_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef struct packed {
    logic [AHB_ADDR_W-1:0] addr;
    logic [1:0]            trans;
    logic                  write;
    logic [2:0]            size;
  } ahb_ap_t;

  // BUSY carries no transfer, so only NONSEQ/SEQ count as a request.
  function automatic logic is_req(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_addr_hold.sv
// One-entry address-phase buffer; a held entry is never overwritten until cleared.
module ahb_addr_hold
  import ahb_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    capture_i,
  input  logic    clear_i,
  input  ahb_ap_t ap_i,
  output ahb_ap_t ap_o,
  output logic    valid_o
);

  ahb_ap_t ap_q;
  logic    valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ap_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (capture_i && !valid_q) begin
      valid_q <= 1'b1;
      ap_q    <= ap_i;
    end
  end

  assign ap_o    = ap_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ahb_lite_arb2.sv
// Two-master AHB-Lite arbiter: per-transfer arbitration, one buffered address per
// master, and data-phase steering of HWDATA/HREADY to the data-phase owner.
module ahb_lite_arb2
  import ahb_pkg::*;
#(
  parameter int ADDR_W   = AHB_ADDR_W,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic              M0_HREADY,
  output logic [DATA_W-1:0] M0_HRDATA,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic              M1_HREADY,
  output logic [DATA_W-1:0] M1_HRDATA,
  output logic [ADDR_W-1:0] S_HADDR,
  output logic [1:0]        S_HTRANS,
  output logic              S_HWRITE,
  output logic [2:0]        S_HSIZE,
  output logic [DATA_W-1:0] S_HWDATA,
  input  logic              S_HREADY,
  input  logic [DATA_W-1:0] S_HRDATA,
  output logic              GNT
);

  ahb_ap_t    live_ap [2];
  ahb_ap_t    pend_ap [2];
  ahb_ap_t    sel_ap;
  logic [1:0] pend_v, pend_nxt, capture, clear, hready, req;
  logic       sel_req, issue;
  logic       gnt_q, gnt_d, last_q, last_d;
  logic       dp_act_q, dp_act_d, dp_own_q, dp_own_d;

  assign live_ap[0] = '{addr: M0_HADDR, trans: M0_HTRANS, write: M0_HWRITE, size: M0_HSIZE};
  assign live_ap[1] = '{addr: M1_HADDR, trans: M1_HTRANS, write: M1_HWRITE, size: M1_HSIZE};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (dp_act_q && (dp_own_q == 1'(i))) begin
        hready[i] = S_HREADY;
      end else if (pend_v[i]) begin
        hready[i] = 1'b0;
      end else begin
        hready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    if (pend_v[gnt_q]) begin
      sel_ap = pend_ap[gnt_q];
    end else begin
      sel_ap = live_ap[gnt_q];
    end
  end

  assign sel_req = is_req(sel_ap.trans);
  assign issue   = S_HREADY & sel_req;

  // The owner's live request goes straight out when the bus is ready; anything
  // else the master believes accepted must be parked so it is never lost.
  for (genvar i = 0; i < 2; i++) begin : g_hold
    assign capture[i]  = hready[i] & is_req(live_ap[i].trans)
                         & ~((gnt_q == 1'(i)) & ~pend_v[i] & S_HREADY);
    assign clear[i]    = issue & (gnt_q == 1'(i)) & pend_v[i];
    assign pend_nxt[i] = ~clear[i] & (pend_v[i] | capture[i]);
    assign req[i]      = pend_nxt[i] | is_req(live_ap[i].trans);

    ahb_addr_hold u_hold (
      .clk_i    (HCLK),
      .rst_ni   (HRESETn),
      .capture_i(capture[i]),
      .clear_i  (clear[i]),
      .ap_i     (live_ap[i]),
      .ap_o     (pend_ap[i]),
      .valid_o  (pend_v[i])
    );
  end

  // Round-robin compares against the just-updated last owner, so the other
  // master gets the very next slot after an issue.
  always_comb begin
    gnt_d    = gnt_q;
    last_d   = last_q;
    dp_act_d = dp_act_q;
    dp_own_d = dp_own_q;
    if (S_HREADY) begin
      dp_act_d = issue;
      if (issue) begin
        dp_own_d = gnt_q;
        last_d   = gnt_q;
      end else begin
        dp_own_d = dp_own_q;
        last_d   = last_q;
      end
      case (req)
        2'b01:   gnt_d = 1'b0;
        2'b10:   gnt_d = 1'b1;
        2'b11:   gnt_d = (ARB_MODE == 1) ? 1'b0 : ~last_d;
        default: gnt_d = gnt_q;
      endcase
    end else begin
      gnt_d = gnt_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      dp_act_q <= 1'b0;
      dp_own_q <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      dp_act_q <= dp_act_d;
      dp_own_q <= dp_own_d;
    end
  end

  assign S_HADDR   = sel_ap.addr;
  assign S_HTRANS  = (HRESETn && sel_req) ? sel_ap.trans : HTRANS_IDLE;
  assign S_HWRITE  = sel_ap.write;
  assign S_HSIZE   = sel_ap.size;
  assign S_HWDATA  = dp_own_q ? M1_HWDATA : M0_HWDATA;
  assign M0_HREADY = hready[0];
  assign M1_HREADY = hready[1];
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign GNT       = gnt_q;

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// Self-checking bench: a round-robin and a fixed-priority instance share stimulus;
// issued address phases are matched against a scoreboard of expected transfers.
module tb_ahb_lite_arb2;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, S_HRDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE, S_HREADY;
  logic [2:0]  M0_HSIZE, M1_HSIZE;

  logic        r_m0_hready, r_m1_hready, r_hwrite, r_gnt;
  logic [31:0] r_m0_hrdata, r_m1_hrdata, r_haddr, r_hwdata;
  logic [1:0]  r_htrans;
  logic [2:0]  r_hsize;
  logic        f_m0_hready, f_m1_hready, f_hwrite, f_gnt;
  logic [31:0] f_m0_hrdata, f_m1_hrdata, f_haddr, f_hwdata;
  logic [1:0]  f_htrans;
  logic [2:0]  f_hsize;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] sb_q[$];
  bit          sel_fp = 1'b0;

  always #5 HCLK = ~HCLK;

  ahb_lite_arb2 #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M0_HREADY(r_m0_hready), .M0_HRDATA(r_m0_hrdata),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HWDATA(M1_HWDATA), .M1_HREADY(r_m1_hready), .M1_HRDATA(r_m1_hrdata),
    .S_HADDR(r_haddr), .S_HTRANS(r_htrans), .S_HWRITE(r_hwrite), .S_HSIZE(r_hsize),
    .S_HWDATA(r_hwdata), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA), .GNT(r_gnt)
  );

  ahb_lite_arb2 #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M0_HREADY(f_m0_hready), .M0_HRDATA(f_m0_hrdata),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HWDATA(M1_HWDATA), .M1_HREADY(f_m1_hready), .M1_HRDATA(f_m1_hrdata),
    .S_HADDR(f_haddr), .S_HTRANS(f_htrans), .S_HWRITE(f_hwrite), .S_HSIZE(f_hsize),
    .S_HWDATA(f_hwdata), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA), .GNT(f_gnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ent(input logic m, input logic w, input logic [31:0] a);
    return {30'd0, m, w, a};
  endfunction

  // Observe issued address phases mid-cycle, away from the clock edge.
  always @(negedge HCLK) begin
    logic [1:0]  t;
    logic [63:0] obs;
    t   = sel_fp ? f_htrans : r_htrans;
    obs = sel_fp ? ent(f_gnt, f_hwrite, f_haddr) : ent(r_gnt, r_hwrite, r_haddr);
    if (HRESETn && S_HREADY && t[1]) begin
      if (sb_q.size() == 0) chk("sb_unexpected", obs, '1);
      else chk("sb_issue", obs, sb_q.pop_front());
    end
  end

  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  task automatic idle_masters();
    M0_HTRANS = HTRANS_IDLE; M1_HTRANS = HTRANS_IDLE;
    M0_HADDR = 32'd0; M1_HADDR = 32'd0; M0_HWRITE = 1'b0; M1_HWRITE = 1'b0;
    M0_HSIZE = HSIZE_WORD; M1_HSIZE = HSIZE_WORD;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    idle_masters();
    S_HREADY = 1'b1;
    sb_q.delete();
    repeat (2) step();
    HRESETn = 1'b1;
  endtask

  task automatic run_pair(input bit fp, input string tag);
    int k0 = 0;
    int k1 = 0;
    bit h0, h1;
    for (int c = 0; c < 40 && !(k0 == 4 && k1 == 4 && sb_q.size() == 0); c++) begin
      M0_HTRANS = (k0 < 4) ? HTRANS_NONSEQ : HTRANS_IDLE;
      M1_HTRANS = (k1 < 4) ? HTRANS_NONSEQ : HTRANS_IDLE;
      M0_HADDR  = 32'h1000_0000 + 32'(k0) * 32'd4;
      M1_HADDR  = 32'h3000_0000 + 32'(k1) * 32'd4;
      #1;
      h0 = fp ? f_m0_hready : r_m0_hready;
      h1 = fp ? f_m1_hready : r_m1_hready;
      step();
      if (h0 && k0 < 4) k0++;
      if (h1 && k1 < 4) k1++;
    end
    idle_masters();
    chk(tag, 64'(sb_q.size()), 64'd0);
    step();
  endtask

  initial begin
    HRESETn = 1'b0;
    idle_masters();
    S_HREADY = 1'b1; S_HRDATA = 32'd0; M0_HWDATA = 32'd0; M1_HWDATA = 32'd0;
    M0_HTRANS = HTRANS_NONSEQ;
    step();
    #1;
    chk("rst_htrans", 64'(r_htrans), 64'(HTRANS_IDLE));
    chk("rst_m0_hready", 64'(r_m0_hready), 64'd1);
    chk("rst_m1_hready", 64'(r_m1_hready), 64'd1);
    chk("rst_gnt", 64'(r_gnt), 64'd0);

    // Owner issues in the same cycle; read data returns in the next.
    do_reset();
    M0_HADDR = 32'h0000_0100; M0_HTRANS = HTRANS_NONSEQ;
    sb_q.push_back(ent(1'b0, 1'b0, 32'h0000_0100));
    #1;
    chk("t1_htrans", 64'(r_htrans), 64'(HTRANS_NONSEQ));
    step();
    idle_masters(); S_HRDATA = 32'hA5A5_0100;
    #1;
    chk("t1_m0_hready", 64'(r_m0_hready), 64'd1);
    chk("t1_m0_hrdata", 64'(r_m0_hrdata), 64'hA5A5_0100);
    chk("t1_m1_hrdata", 64'(r_m1_hrdata), 64'hA5A5_0100);
    step();

    // Simultaneous requests: M0 live now, M1 buffered and issued one cycle later.
    do_reset();
    M0_HADDR = 32'h0000_0200; M0_HTRANS = HTRANS_NONSEQ;
    M1_HADDR = 32'h2000_0000; M1_HTRANS = HTRANS_NONSEQ;
    sb_q.push_back(ent(1'b0, 1'b0, 32'h0000_0200));
    sb_q.push_back(ent(1'b1, 1'b0, 32'h2000_0000));
    #1;
    chk("t2_gnt_t0", 64'(r_gnt), 64'd0);
    step();
    idle_masters(); S_HRDATA = 32'h0000_0202;
    #1;
    chk("t2_m1_hready_t1", 64'(r_m1_hready), 64'd0);
    chk("t2_gnt_t1", 64'(r_gnt), 64'd1);
    chk("t2_m0_hready_t1", 64'(r_m0_hready), 64'd1);
    chk("t2_m0_hrdata", 64'(r_m0_hrdata), 64'h0000_0202);
    step();
    S_HRDATA = 32'hC0DE_0001;
    #1;
    chk("t2_m1_hready_t2", 64'(r_m1_hready), 64'd1);
    chk("t2_m1_hrdata", 64'(r_m1_hrdata), 64'hC0DE_0001);
    step();

    // Continuous requests: alternation under round-robin.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back(ent(1'b0, 1'b0, 32'h1000_0000 + 32'(k) * 32'd4));
      sb_q.push_back(ent(1'b1, 1'b0, 32'h3000_0000 + 32'(k) * 32'd4));
    end
    run_pair(1'b0, "t3_rr_drain");

    // Same stimulus under fixed priority: M0 takes every slot first.
    do_reset();
    sel_fp = 1'b1;
    for (int k = 0; k < 4; k++) sb_q.push_back(ent(1'b0, 1'b0, 32'h1000_0000 + 32'(k) * 32'd4));
    for (int k = 0; k < 4; k++) sb_q.push_back(ent(1'b1, 1'b0, 32'h3000_0000 + 32'(k) * 32'd4));
    run_pair(1'b1, "t3_fp_drain");
    sel_fp = 1'b0;

    // M1 write stalled by the slave; M0 waits in its buffer.
    do_reset();
    M1_HADDR = 32'h4000_0000; M1_HTRANS = HTRANS_NONSEQ; M1_HWRITE = 1'b1;
    sb_q.push_back(ent(1'b1, 1'b1, 32'h4000_0000));
    #1;
    chk("t4_m1_hready_c0", 64'(r_m1_hready), 64'd1);
    step();
    idle_masters(); M1_HWDATA = 32'hDEAD_BEEF;
    step();
    S_HREADY = 1'b0;
    M0_HADDR = 32'h0000_0500; M0_HTRANS = HTRANS_NONSEQ;
    sb_q.push_back(ent(1'b0, 1'b0, 32'h0000_0500));
    #1;
    chk("t4_hwdata_c2", 64'(r_hwdata), 64'hDEAD_BEEF);
    chk("t4_m0_hready_c2", 64'(r_m0_hready), 64'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      chk("t4_hwdata_stall", 64'(r_hwdata), 64'hDEAD_BEEF);
      chk("t4_m0_wait", 64'(r_m0_hready), 64'd0);
      chk("t4_m1_wait", 64'(r_m1_hready), 64'd0);
    end
    step();
    S_HREADY = 1'b1;
    #1;
    chk("t4_m1_done", 64'(r_m1_hready), 64'd1);
    chk("t4_hwdata_end", 64'(r_hwdata), 64'hDEAD_BEEF);
    chk("t4_htrans_c5", 64'(r_htrans), 64'(HTRANS_IDLE));
    step();
    #1;
    chk("t4_gnt_c6", 64'(r_gnt), 64'd0);
    chk("t4_haddr_c6", 64'(r_haddr), 64'h0000_0500);
    step();
    idle_masters();
    #1;
    chk("t4_m0_hready_c7", 64'(r_m0_hready), 64'd1);
    step();

    // Reset with M0's data phase open and M1 buffered.
    do_reset();
    M0_HADDR = 32'h0000_0600; M0_HTRANS = HTRANS_NONSEQ;
    M1_HADDR = 32'h7000_0000; M1_HTRANS = HTRANS_NONSEQ;
    sb_q.push_back(ent(1'b0, 1'b0, 32'h0000_0600));
    step();
    idle_masters(); S_HREADY = 1'b0;
    #1;
    chk("t5_m1_pend", 64'(r_m1_hready), 64'd0);
    HRESETn = 1'b0;
    M0_HADDR = 32'h0000_0800; M0_HTRANS = HTRANS_NONSEQ;
    #1;
    chk("t5_rst_htrans", 64'(r_htrans), 64'(HTRANS_IDLE));
    chk("t5_rst_m0_hready", 64'(r_m0_hready), 64'd1);
    chk("t5_rst_m1_hready", 64'(r_m1_hready), 64'd1);
    step();
    HRESETn = 1'b1; idle_masters(); S_HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_gnt", 64'(r_gnt), 64'd0);
      chk("t5_no_stale", 64'(r_htrans), 64'(HTRANS_IDLE));
      step();
    end
    chk("t5_sb_empty", 64'(sb_q.size()), 64'd0);

    // Back-to-back M0 transfers with no bubbles.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      M0_HADDR = 32'h0000_0300 + 32'(k) * 32'd4; M0_HTRANS = HTRANS_NONSEQ;
      sb_q.push_back(ent(1'b0, 1'b0, 32'h0000_0300 + 32'(k) * 32'd4));
      #1;
      chk("t6_htrans", 64'(r_htrans), 64'(HTRANS_NONSEQ));
      chk("t6_m0_hready", 64'(r_m0_hready), 64'd1);
      step();
    end
    idle_masters();
    step();
    chk("t6_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_lite_arb2.md
Name: ahb_lite_arb2

Overview:
Two-master AHB-Lite arbiter that shares the single system AHB-Lite bus (QSPI flash, SRAM, GPIO, APB bridge) between the Ibex core (M0) and a second master (M1, DMA or debug/loader). It sits between the masters and the AHB-Lite system interconnect. It arbitrates each transfer and buffers an address phase that cannot be issued immediately. It steers the write-data, ready and read-data paths to whichever master owns the current data phase.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority with M0 highest

Ports:
- HCLK, in, 1, system clock
- HRESETn, in, 1, asynchronous active-low reset
- M0_HADDR / M1_HADDR, in, ADDR_W, master address
- M0_HTRANS / M1_HTRANS, in, 2, master transfer type
- M0_HWRITE / M1_HWRITE, in, 1, master write
- M0_HSIZE / M1_HSIZE, in, 3, master size
- M0_HWDATA / M1_HWDATA, in, DATA_W, master write data
- M0_HREADY / M1_HREADY, out, 1, per-master ready
- M0_HRDATA / M1_HRDATA, out, DATA_W, read data, S_HRDATA broadcast to both
- S_HADDR, out, ADDR_W, to interconnect
- S_HTRANS, out, 2, to interconnect
- S_HWRITE, out, 1, to interconnect
- S_HSIZE, out, 3, to interconnect
- S_HWDATA, out, DATA_W, to interconnect
- S_HREADY, in, 1, interconnect ready
- S_HRDATA, in, DATA_W, interconnect read data
- GNT, out, 1, current address-phase owner (0 = M0, 1 = M1)

Behaviour:
Reset (HRESETn low, asynchronous):
- gnt = 0, last = 1, dp_act = 0, pend_v0 = pend_v1 = 0.
- While in reset, S_HTRANS = IDLE and M0_HREADY = M1_HREADY = 1.
- A reset mid-transfer drops every buffered or outstanding transfer. No replay.

State:
- gnt: address owner.
- last: last granted master, used for round-robin.
- dp_act, dp_own: data-phase valid and data-phase owner.
- Per master i: one-entry pending buffer pend_i {HADDR, HTRANS, HWRITE, HSIZE} with valid bit pend_vi.

Transfer semantics:
- A request is HTRANS[1]=1. NONSEQ and SEQ are treated identically; every transfer is arbitrated individually. There is no burst locking and no HRESP.
- BUSY is treated as IDLE.

Per-master ready (combinational):
- Mi_HREADY = S_HREADY when dp_act and dp_own==i.
- Otherwise Mi_HREADY = 0 when pend_vi.
- Otherwise Mi_HREADY = 1.

Slave address mux:
- Source is pend_gnt if pend_v[gnt], else the live signals of master gnt.
- S_HTRANS = IDLE when the selected source has no request.
- S_HWDATA = Mdp_own_HWDATA. Masters hold HWDATA while their HREADY is low.

Issue rules:
- Issue occurs when S_HREADY=1 and the selected source requests.
- On issue: dp_act <= 1, dp_own <= gnt, and pend_v[gnt] clears if the source was the buffer.
- When S_HREADY=1 with no issue: dp_act <= 0.

Capture rule:
- Condition: Mi_HREADY=1, Mi request, and NOT (gnt==i && !pend_vi && S_HREADY).
- Action: load pend_i and set pend_vi.
- This happens exactly once per accepted address. Losing an address is a bug. pend_vi never overwrites.

Arbitration (registered; evaluated only on edges where S_HREADY=1):
- req_i = pend_vi (post-update) or live request from master i.
- If only one master requests, gnt moves to it.
- If both request and ARB_MODE=0, gnt goes to the master != last.
- If both request and ARB_MODE=1, gnt goes to M0.
- If neither requests, gnt parks.
- last <= gnt on every issue.
- With S_HREADY=0, gnt, pend and dp are frozen; capture is still allowed.

Latency:
- Owner's live request is issued in the same cycle.
- A non-owner request is buffered at cycle t, issued at t+1 if S_HREADY, and its data phase runs at t+2.

Simultaneous events:
- A capture and an issue of the same master cannot coincide, because the buffer is empty when issuing live.
- When both masters request in the same cycle, the owner's request issues and the other's is buffered.

Decomposition:
- Shared package ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ constants, HSIZE encodings, and a struct {addr, trans, write, size} for the address phase.
- Sub-module ahb_addr_hold: one-entry buffer with capture/clear, instantiated once per master.

Test Plan:
1. M0 alone issues a read to 0x0000_0100 with S_HREADY=1 -> S_HTRANS=NONSEQ the same cycle; M0_HREADY=1 in the data phase; M0_HRDATA = S_HRDATA.
2. M0 and M1 issue NONSEQ in the same cycle, ARB_MODE=0, gnt=0, last=1 -> M0 is issued at t. M1 is buffered with M1_HREADY=0. M1's address 0x2000_0000 is issued at t+1. M1_HREADY=1 only at its data-phase completion at t+2.
3. Continuous requests from both masters, ARB_MODE=0 -> the issue order alternates M0, M1, M0, M1. With ARB_MODE=1, M0 takes every slot and M1 issues only when M0 goes IDLE.
4. M1 write with HWDATA=0xDEAD_BEEF while S_HREADY is held low for 3 cycles -> S_HWDATA=0xDEAD_BEEF throughout. M0's request is buffered and waits. M0's address is unchanged when it issues after S_HREADY rises.
5. HRESETn asserted while M1's transfer is buffered and M0's data phase is active -> S_HTRANS=IDLE and both HREADY=1 immediately. After release, gnt=0 and no stale transfer is issued.
6. Back-to-back M0 transfers while M1 is idle -> zero arbitration bubbles; S_HTRANS stays NONSEQ on consecutive cycles.
